periph_bus_arbiter: RTL
=======================

// Module: periph_bus_arbiter
// PURPOSE
//   Shares the single memory-mapped peripheral bus (timer, LED, switch and digit registers) between two masters.
//   Master 0 is the CPU data port; master 1 is a secondary engine (e.g. DMA or UART).
//   Uses round-robin arbitration: one transaction per grant.
//   Drives a one-cycle bus strobe, waits the peripheral read latency, then returns registered read data with a done pulse.
//   Sits between the masters and the peripheral block's rd/wr/addr/wdata/rdata port.
// PARAMETERS
//   ADDR_W  32  address width
//   DATA_W  32  data width
//   RD_LAT  1   cycles from rd strobe to valid p_rdata; legal range 1..7
// PORTS
//   clk        in   1       single clock; all logic on posedge
//   reset      in   1       synchronous, active-high reset
//   m0_req     in   1       master 0 request; held with fields stable until m0_gnt
//   m0_wr      in   1       1 = write, 0 = read
//   m0_addr    in   ADDR_W  transaction address
//   m0_wdata   in   DATA_W  write data
//   m0_gnt     out  1       1-cycle pulse: request accepted, bus strobe this cycle
//   m0_done    out  1       1-cycle pulse: transaction complete
//   m0_rdata   out  DATA_W  read data; valid from the m0_done cycle, held until the next m0 read completes
//   m1_*       -    -       identical set for master 1
//   p_rd       out  1       peripheral read strobe
//   p_wr       out  1       peripheral write strobe
//   p_addr     out  ADDR_W  peripheral address
//   p_wdata    out  DATA_W  peripheral write data
//   p_rdata    in   DATA_W  peripheral read data, valid RD_LAT cycles after p_rd
// BEHAVIOUR
//   States: IDLE, ACCESS, WAIT, RESP. Register "last" holds the most recently granted master.
//   Reset (synchronous, wins over everything):
//     state=IDLE, last=1 (master 0 wins the first tie), wait counter=0.
//     All outputs 0, including both rdata registers and p_addr/p_wdata.
//   Arbitration in IDLE and RESP (cycle T):
//     - One req high: pick that master.
//     - Both high: pick !last.
//     - Neither high: go to IDLE.
//     - On a pick: latch wr/addr/wdata, set last=winner, next state ACCESS.
//   ACCESS (T+1):
//     - Winner's gnt=1.
//     - p_wr=wr or p_rd=!wr (never both), p_addr/p_wdata from latched values.
//     - Next state: write -> RESP; read -> WAIT with counter=RD_LAT.
//   WAIT:
//     - Strobes are 0; counter decrements each cycle.
//     - In the cycle the counter equals 1, capture p_rdata into the winner's rdata register, then go to RESP.
//     - WAIT lasts exactly RD_LAT cycles.
//   RESP:
//     - Winner's done=1, strobes 0.
//     - Arbitrates as in IDLE, so back-to-back transactions are possible.
//   Latency from req seen in T:
//     - Write: gnt at T+1, done at T+2.
//     - Read: gnt at T+1, done at T+2+RD_LAT.
//   Request rule:
//     - A master drops req in the cycle after its gnt unless it wants another transaction.
//     - req sampled in RESP is treated as a new request.
//   Strobes last exactly one cycle per transaction. p_addr/p_wdata hold their last value outside ACCESS.
//   The loser's req is ignored, not queued; it is re-arbitrated at the next IDLE/RESP.
//   The non-granted master's gnt, done and rdata never change.
//   Reset mid-transaction (any state):
//     - Next cycle: strobes 0, no done, rdata cleared, state IDLE.
//     - The aborted transaction is not replayed.
//   No address decoding; an unmapped address completes normally (peripheral returns 0).
// TESTING
//   1. m0 write 0x40000004 / 0x000000A5 at T -> p_wr=1 only at T+1 with that addr/data; m0_gnt T+1; m0_done T+2; m1 outputs stay 0.
//   2. m1 read 0x40000005, bus model returns 0x5A one cycle after p_rd -> p_rd only at T+1; m1_done T+3 with m1_rdata=0x0000005A held afterwards.
//   3. Both req at T after reset, both held continuously -> grants alternate m0,m1,m0,m1; no two consecutive grants to one master.
//   4. m0 req held high alone, writes -> gnt every 2 cycles (ACCESS/RESP alternating); p_wr pulses never adjacent.
//   5. reset=1 during WAIT of an m0 read -> next cycle all outputs 0, no m0_done; next tie grants m0 first.
//   6. RD_LAT=3, m0 read at T -> p_rd at T+1; p_rdata sampled at T+4; m0_done T+5; write latency unchanged.

Source files
------------

// File: rtl/periph_bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the peripheral register block.
// The slave modport is the arbiter's view; the master modport is the view of the masters and the peripheral.
interface periph_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Master 0 (CPU data port)
    logic              m0_req;
    logic              m0_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_done;
    logic [DATA_W-1:0] m0_rdata;

    // Master 1 (secondary engine)
    logic              m1_req;
    logic              m1_wr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_done;
    logic [DATA_W-1:0] m1_rdata;

    // Peripheral port
    logic              p_rd;
    logic              p_wr;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_wdata,
        output m0_gnt, m0_done, m0_rdata,
        input  m1_req, m1_wr, m1_addr, m1_wdata,
        output m1_gnt, m1_done, m1_rdata,
        output p_rd, p_wr, p_addr, p_wdata,
        input  p_rdata
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_wdata,
        input  m0_gnt, m0_done, m0_rdata,
        output m1_req, m1_wr, m1_addr, m1_wdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  p_rd, p_wr, p_addr, p_wdata,
        output p_rdata
    );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral register bus between two masters,
// one transaction per grant, with a fixed peripheral read latency.
module periph_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input logic                 clk,
    input logic                 reset,
    periph_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StWait   = 2'd2,
        StResp   = 2'd3
    } state_t;

    localparam logic [2:0] LatCnt = 3'(RD_LAT);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic any_req;
    logic pick;

    assign any_req = bus.m0_req | bus.m1_req;
    // On a tie the master that did not win last time goes next.
    assign pick = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        unique case (state_q)
            StIdle, StResp: begin
                if (any_req) begin
                    state_d = StAccess;
                    last_d  = pick;
                    wr_d    = pick ? bus.m1_wr    : bus.m0_wr;
                    addr_d  = pick ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = pick ? bus.m1_wdata : bus.m0_wdata;
                end else begin
                    state_d = StIdle;
                end
            end
            StAccess: begin
                if (wr_q) begin
                    state_d = StResp;
                end else begin
                    state_d = StWait;
                    cnt_d   = LatCnt;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StResp;
                    if (last_q) begin
                        rdata1_d = bus.p_rdata;
                    end else begin
                        rdata0_d = bus.p_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // last_q always names the master owning the transaction in flight.
    assign bus.m0_gnt   = (state_q == StAccess) & ~last_q;
    assign bus.m1_gnt   = (state_q == StAccess) &  last_q;
    assign bus.m0_done  = (state_q == StResp)   & ~last_q;
    assign bus.m1_done  = (state_q == StResp)   &  last_q;
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;

    assign bus.p_wr    = (state_q == StAccess) &  wr_q;
    assign bus.p_rd    = (state_q == StAccess) & ~wr_q;
    assign bus.p_addr  = addr_q;
    assign bus.p_wdata = wdata_q;

endmodule
